fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter N, 32, instruction/PC width in bits.
REQ-002 Parameter A, 10, instruction-memory byte-address width.
REQ-003 Parameter RESET_PC, 32'h0, PC value loaded on reset.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 imem_addr  output  A  byte address to instruction memory, equals pc_q[A-1:0], combinational.
REQ-007 imem_data  input  N  instruction word, combinationally returned for imem_addr in the same cycle.
REQ-008 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-009 redirect_pc  input  N  redirect target.
REQ-010 out_valid  output  1  fetched instruction presented to decode.
REQ-011 out_ready  input  1  decode accepts this cycle.
REQ-012 out_instr  output  N  fetched instruction.
REQ-013 out_pc  output  N  address of out_instr.
REQ-014 halted  output  1  high while in HALT state.
REQ-015 fetch_count  output  N  number of completed fetches.

Function
REQ-016 State machine with two states, RUN and HALT, shall be implemented.
REQ-017 fetch_fire shall equal (state==RUN) && !redirect_valid && (!out_valid || out_ready).
REQ-018 On fetch_fire: out_instr<=imem_data, out_pc<=pc_q, out_valid<=1, pc_q<=pc_q+4 (mod 2^N), fetch_count<=fetch_count+1 (mod 2^N).
REQ-019 When out_valid && out_ready && !fetch_fire, out_valid shall clear on the next edge.
REQ-020 When out_valid && !out_ready, out_instr/out_pc/out_valid shall hold unchanged, and pc_q shall hold.
REQ-021 redirect_valid shall have priority over all other events: pc_q<={redirect_pc[N-1:2],2'b00}, out_valid<=0 (flush, regardless of out_ready), state<=RUN.
REQ-022 Redirect latency: redirect in cycle t gives out_valid=1 with out_pc=target in cycle t+2, with out_ready high.
REQ-023 If fetch_fire loads imem_data==32'h00100073 (EBREAK), state shall go to HALT on the same edge, and the EBREAK shall still be presented on out_instr.
REQ-024 In HALT, no fetch shall occur, and pc_q and fetch_count shall hold; the already-presented instruction shall complete normally under out_ready.
REQ-025 HALT shall be exited only by redirect_valid or rst.
REQ-026 pc_q wrap at 2^N-4 -> 0 shall be silent; imem_addr shall wrap modulo 2^A.
REQ-027 Throughput shall be one instruction per cycle while out_ready is held high.

Reset
REQ-028 On rst: pc_q=RESET_PC, out_valid=0, out_instr=0, out_pc=0, state=RUN, halted=0, fetch_count=0.
REQ-029 rst shall override redirect_valid and any in-flight handshake.
REQ-030 First cycle after rst deasserts, fetch_fire is possible; out_valid=1 with out_pc=RESET_PC in the following cycle.

Structure
REQ-031 Shared package riscv_pkg shall hold the state enum fetch_state_t {RUN,HALT} and the constant EBREAK_INSN=32'h00100073.
REQ-032 No sub-module; the block shall instantiate nothing, and instruction_memory shall be connected at the level above.

Verification
REQ-033 Reset release with mem[0..3]=11,22,33,44 and out_ready=1 -> out_pc 0,4,8,12 with out_instr 11,22,33,44 in consecutive cycles, fetch_count=4.
REQ-034 out_ready=0 for 3 cycles mid-stream at out_pc=8 -> out_instr/out_pc stable for 3 cycles, no PC skipped, next out_pc=12.
REQ-035 redirect_valid with redirect_pc=0x43 while out_valid=1, out_ready=0 -> out_valid=0 next cycle, out_pc=0x40 two cycles later.
REQ-036 EBREAK at address 0x10 -> out_instr=0x00100073, halted=1, no further out_valid after acceptance; redirect to 0x0 -> halted=0, fetch resumes at 0x0.
REQ-037 rst asserted while out_valid=1 and in HALT -> all outputs at reset values next cycle.
REQ-038 Redirect to 0xFFFFFFFC -> out_pc sequence 0xFFFFFFFC, 0x0; imem_addr 0x3FC, 0x000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: the fetch state encoding and the
// instruction word that stops fetching.
package riscv_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch: one registered fetch slot in front of
// decode, with redirect flush and an EBREAK halt.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int             N        = 32,
    parameter int             A        = 10,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [A-1:0]     imem_addr,
    input  logic [N-1:0]     imem_data,
    input  logic             redirect_valid,
    input  logic [N-1:0]     redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_instr,
    output logic [N-1:0]     out_pc,
    output logic             halted,
    output logic [N-1:0]     fetch_count
);

    fetch_state_t state;
    logic [N-1:0] pc_q;
    logic         fetch_fire;
    logic [N-1:0] redirect_target;
    logic         is_ebreak;

    // Memory returns the word combinationally; its address wraps with the low PC bits.
    assign imem_addr       = pc_q[A-1:0];
    assign fetch_fire      = (state == RUN) && !redirect_valid && (!out_valid || out_ready);
    assign redirect_target = redirect_pc & ~N'(3);
    assign is_ebreak       = (imem_data == N'(EBREAK_INSN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            halted      <= 1'b0;
            pc_q        <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            fetch_count <= '0;
        end else if (redirect_valid) begin
            // Redirect flushes the slot even if decode is accepting it this cycle.
            state     <= RUN;
            halted    <= 1'b0;
            pc_q      <= redirect_target;
            out_valid <= 1'b0;
        end else if (fetch_fire) begin
            out_instr   <= imem_data;
            out_pc      <= pc_q;
            out_valid   <= 1'b1;
            pc_q        <= pc_q + N'(4);
            fetch_count <= fetch_count + N'(1);
            if (is_ebreak) begin
                state  <= HALT;
                halted <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
